gps_report_packer: RTL and testbench
====================================

// Module: gps_report_packer
// PURPOSE
//  Downstream consumer of the GPS query engine's decoded register outputs.
//  Detects completion of each full query sweep (current_query wraps 9 -> 0).
//  Takes a coherent snapshot of all fields and streams it as a framed, checksummed
//  byte packet on a valid/ready byte interface toward a host UART or FIFO.
// PARAMETERS
//  HEADER_BYTE  8'hA5  first byte of every frame
//  DECIMATE     1      emit one frame per DECIMATE completed sweeps (1..255)
//  DROP_CNT_W   8      width of saturating dropped-frame counter
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  current_query in  4   query index from GPS engine (0..9)
//  hw_version   in   8   | info_valid in 1 | sats in 4
//  gmt_time     in   24  | gmt_date in 24
//  lattitude    in   40  | longitude in 40
//  altitude     in   16  | speed in 16 | heading in 16
//  out_data     out  8   frame byte
//  out_valid    out  1   out_data valid; held until out_ready
//  out_ready    in   1   sink accepts byte when out_valid & out_ready
//  busy         out  1   frame in flight
//  frames_sent  out  16  wrapping count of completed frames
//  frames_dropped out DROP_CNT_W  saturating count of eligible sweeps skipped while busy
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, busy=0, counters=0, decimation cnt=0, cq_q=0, state IDLE.
//  - sweep_done = (cq_q==9) & (current_query==0); cq_q is current_query registered each cycle.
//  - Decimation counter dc: on sweep_done, eligible = (dc==DECIMATE-1); dc wraps to 0 if eligible, else dc+1.
//  - Eligible & free: snapshot of all inputs latched on that edge; out_valid=1 with HEADER_BYTE next cycle.
//  - free = IDLE, or last byte (CSUM) handshaking in same cycle -> back-to-back frames, no idle gap.
//  - Eligible & not free: frame dropped; frames_dropped++ saturating at all-ones; snapshot untouched.
//  - Frame bytes, MSB-first per field: HDR, LEN, [SEQ], hw_version, {info_valid,3'b0,sats},
//    gmt_time[3], gmt_date[3], lat[5], lon[5], alt[2], speed[2], heading[2], CSUM.
//  - Payload = 24 bytes; LEN = payload bytes incl SEQ if present (24 or 25).
//  - CSUM: 8-bit two's-complement such that (LEN + [SEQ] + payload + CSUM) mod 256 == 0; HDR excluded.
//    Accumulated incrementally as bytes handshake; no wide adder tree.
//  - FSM: IDLE -> HDR -> LEN -> [SEQ] -> PAYLOAD (idx 0..23) -> CSUM -> IDLE, or HDR if re-triggered.
//    Advance only on out_valid & out_ready; out_data/out_valid stable while stalled.
//  - frames_sent++ on CSUM handshake; wraps at 16 bits.
//  - busy = (state != IDLE).
//  - Snapshot is never overwritten mid-frame; inputs changing mid-frame have no effect.
//  - Reset mid-frame: frame abandoned, out_valid=0 the cycle after rst sampled; no partial resume.
//  - current_query values 10..15 ignored except as cq_q history (never form sweep_done).
// CONFIGURATION
//  GPS_PACK_SEQNUM_EN defined: 8-bit frame sequence byte after LEN; LEN=25.
//    SEQ starts 0 at reset, +1 per emitted frame (wraps), included in CSUM.
//  Not defined: no SEQ state, LEN=24, frame is 27 bytes.
// STRUCTURE
//  gps_pkg: state typedef; PAYLOAD_BYTES=24; field byte-offset localparams; DEFAULT_HEADER=8'hA5.
//  Single module; snapshot is a 192-bit payload register indexed by byte counter.
//  No sub-module warranted.
// TESTING
//  1. Fields hw=8'h12, sats=7, valid=1, lat=40'h2A_1B_FFFF_00; step cq 9->0; ready=1.
//     -> 27 bytes: A5,18,12,87,...; sum(bytes[1:26]) mod 256 == 0.
//  2. Random out_ready (30% duty) during frame -> identical byte sequence to test 1;
//     data held stable while stalled.
//  3. Second sweep_done mid-frame -> frames_dropped=1, current frame unaltered.
//     sweep_done same cycle as CSUM handshake -> new HDR next cycle, no drop.
//  4. DECIMATE=3, 7 sweeps, ready=1 -> frames on sweeps 3 and 6 only; frames_sent=2.
//  5. rst asserted at PAYLOAD idx 10 -> out_valid=0, busy=0 next cycle.
//     Next sweep yields complete fresh frame.
//  6. With GPS_PACK_SEQNUM_EN: three frames -> LEN=8'h19, SEQ=0,1,2; CSUM still zero-sums.

Source files
------------

// File: rtl/gps_report_packer_pkg.sv
// Shared types and constants for the GPS report packer.
// GPS_PACK_SEQNUM_EN adds a frame sequence byte after LEN.
package gps_report_packer_pkg;

  localparam int unsigned PAYLOAD_BYTES  = 24;
  localparam int unsigned PAYLOAD_W      = PAYLOAD_BYTES * 8;
  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

  localparam int unsigned OFF_HW      = 0;
  localparam int unsigned OFF_STATUS  = 1;
  localparam int unsigned OFF_TIME    = 2;
  localparam int unsigned OFF_DATE    = 5;
  localparam int unsigned OFF_LAT     = 8;
  localparam int unsigned OFF_LON     = 13;
  localparam int unsigned OFF_ALT     = 18;
  localparam int unsigned OFF_SPEED   = 20;
  localparam int unsigned OFF_HEADING = 22;

`ifdef GPS_PACK_SEQNUM_EN
  localparam logic [7:0] FRAME_LEN = 8'(PAYLOAD_BYTES + 1);
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_SEQ, ST_PAYLOAD, ST_CSUM
  } state_e;
`else
  localparam logic [7:0] FRAME_LEN = 8'(PAYLOAD_BYTES);
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_PAYLOAD, ST_CSUM
  } state_e;
`endif

  // Byte 0 of the payload sits in the top byte of the register.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [7:0]  hw,
    input logic        info_valid,
    input logic [3:0]  sats,
    input logic [23:0] gmt_time,
    input logic [23:0] gmt_date,
    input logic [39:0] lat,
    input logic [39:0] lon,
    input logic [15:0] alt,
    input logic [15:0] spd,
    input logic [15:0] hdg
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[PAYLOAD_W-1-8*OFF_HW      -: 8]  = hw;
    p[PAYLOAD_W-1-8*OFF_STATUS  -: 8]  = {info_valid, 3'b000, sats};
    p[PAYLOAD_W-1-8*OFF_TIME    -: 24] = gmt_time;
    p[PAYLOAD_W-1-8*OFF_DATE    -: 24] = gmt_date;
    p[PAYLOAD_W-1-8*OFF_LAT     -: 40] = lat;
    p[PAYLOAD_W-1-8*OFF_LON     -: 40] = lon;
    p[PAYLOAD_W-1-8*OFF_ALT     -: 16] = alt;
    p[PAYLOAD_W-1-8*OFF_SPEED   -: 16] = spd;
    p[PAYLOAD_W-1-8*OFF_HEADING -: 16] = hdg;
    return p;
  endfunction

  function automatic logic [7:0] payload_byte(
    input logic [PAYLOAD_W-1:0] p,
    input logic [4:0]           idx
  );
    logic [PAYLOAD_W-1:0] s;
    s = p << (8 * int'(idx));
    return s[PAYLOAD_W-1 -: 8];
  endfunction

endpackage

// File: rtl/gps_report_packer.sv
// Snapshots GPS engine fields on each (decimated) sweep completion and streams a
// framed, checksummed byte packet. GPS_PACK_SEQNUM_EN inserts a sequence byte.
module gps_report_packer
  import gps_report_packer_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE = DEFAULT_HEADER,
  parameter int unsigned DECIMATE    = 1,
  parameter int unsigned DROP_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            current_query,
  input  logic [7:0]            hw_version,
  input  logic                  info_valid,
  input  logic [3:0]            sats,
  input  logic [23:0]           gmt_time,
  input  logic [23:0]           gmt_date,
  input  logic [39:0]           lattitude,
  input  logic [39:0]           longitude,
  input  logic [15:0]           altitude,
  input  logic [15:0]           speed,
  input  logic [15:0]           heading,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           frames_sent,
  output logic [DROP_CNT_W-1:0] frames_dropped
);

  localparam logic [7:0] DC_LAST  = 8'(DECIMATE - 1);
  localparam logic [4:0] IDX_LAST = 5'(PAYLOAD_BYTES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cq_q;
  logic [7:0]            dc_q;
  logic [4:0]            idx_q;
  logic [PAYLOAD_W-1:0]  snap_q;
  logic [7:0]            acc_q;
  logic [15:0]           sent_q;
  logic [DROP_CNT_W-1:0] drop_q;
`ifdef GPS_PACK_SEQNUM_EN
  logic [7:0]            seq_q;
`endif
  logic hs, sweep_done, eligible, free, trigger;

  assign hs         = out_valid & out_ready;
  assign sweep_done = (cq_q == 4'd9) && (current_query == 4'd0);
  assign eligible   = sweep_done && (dc_q == DC_LAST);
  // Accepting the checksum byte frees the engine in the same cycle: no idle gap.
  assign free       = (state_q == ST_IDLE) || ((state_q == ST_CSUM) && out_ready);
  assign trigger    = eligible && free;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (trigger) state_d = ST_HDR;
      ST_HDR:     if (hs) state_d = ST_LEN;
`ifdef GPS_PACK_SEQNUM_EN
      ST_LEN:     if (hs) state_d = ST_SEQ;
      ST_SEQ:     if (hs) state_d = ST_PAYLOAD;
`else
      ST_LEN:     if (hs) state_d = ST_PAYLOAD;
`endif
      ST_PAYLOAD: if (hs && idx_q == IDX_LAST) state_d = ST_CSUM;
      ST_CSUM:    if (hs) state_d = trigger ? ST_HDR : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q != ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_data  = '0;
    case (state_q)
      ST_HDR:     out_data = HEADER_BYTE;
      ST_LEN:     out_data = FRAME_LEN;
`ifdef GPS_PACK_SEQNUM_EN
      ST_SEQ:     out_data = seq_q;
`endif
      ST_PAYLOAD: out_data = payload_byte(snap_q, idx_q);
      ST_CSUM:    out_data = 8'd0 - acc_q;
      default:    out_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_q   <= '0;
      dc_q   <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      acc_q  <= '0;
      sent_q <= '0;
      drop_q <= '0;
`ifdef GPS_PACK_SEQNUM_EN
      seq_q  <= '0;
`endif
    end else begin
      cq_q <= current_query;
      if (sweep_done) dc_q <= eligible ? '0 : dc_q + 8'd1;
      if (trigger)
        snap_q <= pack_payload(hw_version, info_valid, sats, gmt_time, gmt_date,
                               lattitude, longitude, altitude, speed, heading);
      if (eligible && !free && drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
      if (hs) begin
        // Checksum restarts at LEN, so a back-to-back frame needs no clear.
        case (state_q)
          ST_LEN:     acc_q <= out_data;
`ifdef GPS_PACK_SEQNUM_EN
          ST_SEQ:     acc_q <= acc_q + out_data;
`endif
          ST_PAYLOAD: begin
            acc_q <= acc_q + out_data;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 5'd1;
          end
          ST_CSUM: begin
            sent_q <= sent_q + 16'd1;
`ifdef GPS_PACK_SEQNUM_EN
            seq_q  <= seq_q + 8'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign frames_sent    = sent_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_gps_report_packer.sv
// Directed bench for gps_report_packer; a DECIMATE=3 instance covers decimation.
module tb_gps_report_packer;

`ifdef GPS_PACK_SEQNUM_EN
  localparam int         FLEN    = 28;
  localparam int         HAS_SEQ = 1;
  localparam logic [7:0] EXP_LEN = 8'h19;
`else
  localparam int         FLEN    = 27;
  localparam int         HAS_SEQ = 0;
  localparam logic [7:0] EXP_LEN = 8'h18;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cq = 4'd0;
  logic [7:0]  hw = 8'h12;
  logic        info_v = 1'b1;
  logic [3:0]  sats = 4'd7;
  logic [23:0] gtime = 24'h123456;
  logic [23:0] gdate = 24'h010203;
  logic [39:0] lat = 40'h2A_1B_FF_FF_00;
  logic [39:0] lon = 40'h01_02_03_04_05;
  logic [15:0] alt = 16'h0BB8;
  logic [15:0] spd = 16'h0010;
  logic [15:0] hdg = 16'h0168;
  logic        out_ready = 1'b0;

  logic [7:0]  out_data, out_data3;
  logic        out_valid, out_valid3, busy, busy3;
  logic [15:0] frames_sent, frames_sent3;
  logic [7:0]  frames_dropped, frames_dropped3;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_f [32];
  logic [7:0] got_f [32];
  logic [7:0] exp_seq = 8'd0;

  always #5 clk = ~clk;

  gps_report_packer #(.HEADER_BYTE(8'hA5), .DECIMATE(1), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .current_query(cq), .hw_version(hw), .info_valid(info_v),
    .sats(sats), .gmt_time(gtime), .gmt_date(gdate), .lattitude(lat), .longitude(lon),
    .altitude(alt), .speed(spd), .heading(hdg), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frames_sent(frames_sent),
    .frames_dropped(frames_dropped)
  );

  gps_report_packer #(.HEADER_BYTE(8'hA5), .DECIMATE(3), .DROP_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .current_query(cq), .hw_version(hw), .info_valid(info_v),
    .sats(sats), .gmt_time(gtime), .gmt_date(gdate), .lattitude(lat), .longitude(lon),
    .altitude(alt), .speed(spd), .heading(hdg), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(1'b1), .busy(busy3), .frames_sent(frames_sent3),
    .frames_dropped(frames_dropped3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame from the current field values and sequence number.
  task automatic build_exp();
    logic [191:0] p, s;
    logic [7:0]   sum;
    int           n;
    p = {hw, info_v, 3'b000, sats, gtime, gdate, lat, lon, alt, spd, hdg};
    exp_f[0] = 8'hA5;
    exp_f[1] = EXP_LEN;
    n = 2;
    if (HAS_SEQ != 0) begin exp_f[2] = exp_seq; n = 3; end
    for (int i = 0; i < 24; i++) begin
      s = p >> (8 * (23 - i));
      exp_f[n] = s[7:0];
      n++;
    end
    sum = 8'd0;
    for (int i = 1; i < n; i++) sum = sum + exp_f[i];
    exp_f[n] = 8'd0 - sum;
  endtask

  task automatic do_sweep();
    @(negedge clk) cq = 4'd9;
    @(negedge clk) cq = 4'd0;
  endtask

  // Collects one frame; retrig schedules a sweep_done on the checksum handshake.
  task automatic collect(input string tag, input bit rnd, input bit retrig, output int wait_cyc);
    int         n;
    int         cyc;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] sum;
    n = 0; cyc = 0; stalled = 0; held = 8'd0; wait_cyc = 0;
    while (n < FLEN && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) check_eq({tag, "_stall_hold"}, 32'({out_valid, out_data}), 32'({1'b1, held}));
      if (!out_valid) begin
        stalled = 0;
        out_ready = 1'b1;
        if (n == 0) wait_cyc++;
      end else begin
        if (retrig && n == FLEN - 2) cq = 4'd9;
        if (retrig && n == FLEN - 1) cq = 4'd0;
        out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        if (out_ready) begin
          got_f[n] = out_data;
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = out_data;
        end
      end
    end
    check_eq({tag, "_bytes"}, 32'(n), 32'(FLEN));
    if (n == FLEN) begin
      for (int i = 0; i < FLEN; i++)
        check_eq($sformatf("%s_b%0d", tag, i), 32'(got_f[i]), 32'(exp_f[i]));
      sum = 8'd0;
      for (int i = 1; i < FLEN; i++) sum = sum + got_f[i];
      check_eq({tag, "_zero_sum"}, 32'(sum), 32'd0);
      exp_seq = exp_seq + 8'd1;
    end
  endtask

  initial begin
    int w;
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sent", 32'(frames_sent), 32'd0);
    check_eq("rst_drop", 32'(frames_dropped), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic frame, ready held high.
    build_exp();
    do_sweep();
    collect("t1", 0, 0, w);
    check_eq("t1_latency", 32'(w), 32'd0);
    check_eq("t1_hdr", 32'(got_f[0]), 32'hA5);
    check_eq("t1_len", 32'(got_f[1]), 32'(EXP_LEN));
    check_eq("t1_hw", 32'(got_f[2 + HAS_SEQ]), 32'h12);
    check_eq("t1_status", 32'(got_f[3 + HAS_SEQ]), 32'h87);
    check_eq("t1_lat0", 32'(got_f[10 + HAS_SEQ]), 32'h2A);
`ifdef GPS_PACK_SEQNUM_EN
    check_eq("t6_seq0", 32'(got_f[2]), 32'd0);
`endif
    repeat (2) @(negedge clk);
    check_eq("t1_sent", 32'(frames_sent), 32'd1);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // Same fields, stalling sink.
    build_exp();
    do_sweep();
    collect("t2", 1, 0, w);
`ifdef GPS_PACK_SEQNUM_EN
    check_eq("t6_seq1", 32'(got_f[2]), 32'd1);
`endif
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Sweep mid-frame is dropped; field changes mid-frame must not leak in.
    build_exp();
    do_sweep();
    fork
      collect("t3", 0, 0, w);
      begin
        repeat (5) @(negedge clk);
        hw = 8'h34; sats = 4'd3; info_v = 1'b0; lat = 40'h11_22_33_44_55; hdg = 16'hBEEF;
        do_sweep();
      end
    join
`ifdef GPS_PACK_SEQNUM_EN
    check_eq("t6_seq2", 32'(got_f[2]), 32'd2);
`endif
    check_eq("t3_dropped", 32'(frames_dropped), 32'd1);
    repeat (2) @(negedge clk);

    // Sweep coinciding with the checksum handshake starts the next frame at once.
    build_exp();
    do_sweep();
    collect("t3b_first", 0, 1, w);
    build_exp();
    collect("t3b_second", 0, 0, w);
    check_eq("t3b_gap", 32'(w), 32'd0);
    check_eq("t3b_dropped", 32'(frames_dropped), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("t3b_sent", 32'(frames_sent), 32'd5);

    // Reset at payload byte 10.
    build_exp();
    do_sweep();
    repeat (2 + HAS_SEQ + 10) @(negedge clk);
    @(negedge clk);
    check_eq("t5_at_idx10", 32'(out_data), 32'(exp_f[12 + HAS_SEQ]));
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_valid", 32'(out_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_seq = 8'd0;
    build_exp();
    do_sweep();
    collect("t5_fresh", 0, 0, w);
    repeat (2) @(negedge clk);
    check_eq("t5_sent", 32'(frames_sent), 32'd1);

    // Decimation and ignored out-of-range query indices.
    rst = 1'b1;
    cq = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk) cq = 4'd9;
    @(negedge clk) cq = 4'd12;
    @(negedge clk) cq = 4'd0;
    @(negedge clk);
    check_eq("cq12_busy", 32'(busy), 32'd0);
    check_eq("cq12_busy3", 32'(busy3), 32'd0);
    for (int k = 0; k < 7; k++) begin
      do_sweep();
      @(negedge clk);
      check_eq($sformatf("t4_busy_s%0d", k), 32'(busy3), 32'((k % 3) == 2));
      check_eq($sformatf("t4_valid_s%0d", k), 32'(out_valid3), 32'((k % 3) == 2));
      check_eq($sformatf("t4_data_s%0d", k), 32'(out_data3), ((k % 3) == 2) ? 32'hA5 : 32'h0);
      repeat (30) @(negedge clk);
    end
    check_eq("t4_sent3", 32'(frames_sent3), 32'd2);
    check_eq("t4_drop3", 32'(frames_dropped3), 32'd0);
    check_eq("t4_sent1", 32'(frames_sent), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
